// File: rtl/logic_unit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_pkg
// Desc    : Opcode and FSM state types shared by the logic-unit arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_arbiter_if
// Desc    : Requester-side and shared-unit-side signals of the arbiter.
//           resp_err exists only when LU_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
interface logic_unit_arbiter_if
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_data;
`ifdef LU_TIMEOUT_EN
  logic                     resp_err;
`endif
  logic                     lu_start;
  op_t                      lu_op;
  logic [WIDTH-1:0]         lu_a;
  logic [WIDTH-1:0]         lu_b;
  logic [WIDTH-1:0]         lu_result;
  logic                     lu_done;

  modport slave (
    input  req_valid, req_op, req_a, req_b, lu_result, lu_done,
    output req_ready, resp_valid, resp_data, lu_start, lu_op, lu_a, lu_b
`ifdef LU_TIMEOUT_EN
    , output resp_err
`endif
  );

  modport master (
    output req_valid, req_op, req_a, req_b, lu_result, lu_done,
    input  req_ready, resp_valid, resp_data, lu_start, lu_op, lu_a, lu_b
`ifdef LU_TIMEOUT_EN
    , input resp_err
`endif
  );

endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Desc    : Combinational round-robin pick: first set req bit from ptr upward.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Distance k from ptr is scanned in order; candidate i matches when i == (ptr+k) mod N.
  always_comb begin
    int pos;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && req[i] && (i == pos)) begin
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_arbiter
// Desc    : Round-robin sharing of one bitwise logic unit between requesters.
//           Optional WAIT timeout with resp_err: define LU_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
`ifdef LU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_unit_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  op_t              lu_op_q, lu_op_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;

`ifdef LU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lu_op_d     = lu_op_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    resp_data_d = resp_data_q;
`ifdef LU_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        // A grant always names a valid requester, so grant == handshake here.
        if (gnt_any) begin
          owner_d = gnt_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
              lu_op_d = op_t'(bus.req_op[2*i +: 2]);
              lu_a_d  = bus.req_a[i*WIDTH +: WIDTH];
              lu_b_d  = bus.req_b[i*WIDTH +: WIDTH];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef LU_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.lu_done) begin
          resp_data_d = bus.lu_result;
`ifdef LU_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef LU_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d = '0;
          err_d       = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lu_op_q     <= OP_AND;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      resp_data_q <= '0;
`ifdef LU_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lu_op_q     <= lu_op_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      resp_data_q <= resp_data_d;
`ifdef LU_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Ready is masked during reset so a held request cannot look accepted.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i]  = rst_n && (state_q == IDLE) && gnt[i];
      bus.resp_valid[i] = (state_q == RESP) && (owner_q == IDX_W'(i));
    end
  end

  assign bus.lu_start  = (state_q == ISSUE);
  assign bus.lu_op     = lu_op_q;
  assign bus.lu_a      = lu_a_q;
  assign bus.lu_b      = lu_b_q;
  assign bus.resp_data = resp_data_q;
`ifdef LU_TIMEOUT_EN
  assign bus.resp_err  = (state_q == RESP) && err_q;
`endif

endmodule
`default_nettype wire
